pio_in_capture: RTL

- Parametrised Avalon-MM input PIO slave and successor to the fixed 32-bit input port.
- Adds:
  - configurable width;
  - metastability synchroniser;
  - per-bit edge capture with selectable edge type;
  - interrupt mask register;
  - level- or edge-sensitive interrupt output.
- Sits on the Nios II data master fabric, alongside the existing PIO peripherals.

---
 rtl/pio_pkg.sv | 32 +++
 rtl/pio_sync_chain.sv | 30 +++
 rtl/pio_in_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register word addresses, edge-select and
// interrupt-mode encodings, and the edge-selection helper.
package pio_pkg;

   localparam int BUS_WIDTH = 32;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
   localparam logic [1:0] ADDR_RESERVED = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

   // Picks the edge terms of interest; anything other than rise/fall means both.
   function automatic logic [BUS_WIDTH-1:0] edge_select(
      input logic [BUS_WIDTH-1:0] rise,
      input logic [BUS_WIDTH-1:0] fall,
      input int                   edge_type
   );
      logic [BUS_WIDTH-1:0] sel;
      sel = rise | fall;
      if (edge_type == EDGE_RISE) sel = rise;
      if (edge_type == EDGE_FALL) sel = fall;
      return sel;
   endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs; each bit is resynchronised
// independently, so multi-bit values may settle over different cycles.
module pio_sync_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= async_i;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO with synchroniser, per-bit sticky edge capture, irq mask
// and level- or edge-sensitive interrupt.
module pio_in_capture
   import pio_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int EDGE_TYPE    = EDGE_RISE,
   parameter int IRQ_TYPE     = IRQ_EDGE,
   parameter int BIT_CLEAR_EN = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   // Bus semantics: a write is chipselect & ~write_n, accepted in the cycle it
   // is presented (no wait states). Reads need no strobe: readdata always shows
   // the register selected by address one clock earlier and has no side effects.

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

   logic [DATA_WIDTH-1:0] sync;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] fall;
   logic [DATA_WIDTH-1:0] edge_sel;
   logic [DATA_WIDTH-1:0] edge_hit;
   logic [DATA_WIDTH-1:0] clr_bits;
   logic [DATA_WIDTH-1:0] cap_q;
   logic [DATA_WIDTH-1:0] cap_d;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [DATA_WIDTH-1:0] mask_d;
   logic [ARM_W-1:0]      arm_q;
   logic [ARM_W-1:0]      arm_d;
   logic                  armed;
   logic                  wr_en;
   logic                  cap_wr;
   logic                  mask_wr;
   logic                  irq_d;
   logic [31:0]           readdata_d;
   logic [31:0]           edge_wide;

   pio_sync_chain #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .async_i (in_port),
      .sync_o  (sync)
   );

   assign wr_en   = chipselect & ~write_n;
   assign cap_wr  = wr_en && (address == ADDR_EDGECAP);
   assign mask_wr = wr_en && (address == ADDR_IRQMASK);

   // The arm counter hides the spurious edge seen while the synchroniser and
   // prev flops fill from reset with inputs already high.
   assign armed = (arm_q == ARM_DONE);
   assign arm_d = armed ? arm_q : arm_q + 1'b1;

   always_comb begin
      rise      = sync & ~prev_q;
      fall      = ~sync & prev_q;
      edge_wide = edge_select(BUS_WIDTH'(rise), BUS_WIDTH'(fall), EDGE_TYPE);
      edge_sel  = edge_wide[DATA_WIDTH-1:0];
      edge_hit  = armed ? edge_sel : '0;
   end

   // New edges take priority over a clear of the same bit.
   always_comb begin
      clr_bits = cap_wr ? writedata[DATA_WIDTH-1:0] : '0;
      if (BIT_CLEAR_EN != 0) begin
         cap_d = (cap_q & ~clr_bits) | edge_hit;
      end else if (cap_wr) begin
         cap_d = edge_hit;
      end else begin
         cap_d = cap_q | edge_hit;
      end
   end

   assign mask_d = mask_wr ? writedata[DATA_WIDTH-1:0] : mask_q;

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = sync;
         ADDR_IRQMASK: readdata_d[DATA_WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: readdata_d[DATA_WIDTH-1:0] = cap_q;
         default:      readdata_d = '0;
      endcase
   end

   always_comb begin
      if (IRQ_TYPE == IRQ_EDGE) begin
         irq_d = |(cap_q & mask_q);
      end else begin
         irq_d = |(sync & mask_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q   <= '0;
         cap_q    <= '0;
         mask_q   <= '0;
         arm_q    <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         prev_q   <= sync;
         cap_q    <= cap_d;
         mask_q   <= mask_d;
         arm_q    <= arm_d;
         readdata <= readdata_d;
         irq      <= irq_d;
      end
   end

endmodule
